// File: rtl/sent_pkg.sv
// Shared constants and types for the SENT receive CRC checker.
// Holds the SAE J2716 CRC4 lookup table (x^4+x^3+x^2+1), seed, frame length limits and FSM states.
package sent_pkg;

  // Entry i sits at bits [4*i +: 4]; entry 0 is the least significant nibble.
  localparam logic [63:0] TBL = {4'd5, 4'd8, 4'd2, 4'd15, 4'd11, 4'd6, 4'd12, 4'd1,
                                 4'd4, 4'd9, 4'd3, 4'd14, 4'd10, 4'd7, 4'd13, 4'd0};

  localparam logic [3:0] CRC_SEED = 4'h5;
  localparam logic [2:0] LEN_MIN  = 3'd1;
  localparam logic [2:0] LEN_MAX  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } sent_state_e;

endpackage

// File: rtl/sent_crc4_nib.sv
// One combinational CRC4 nibble step: crc_out = TBL[crc_in] ^ nib.
// Zero latency; no handshake of its own.
module sent_crc4_nib
  import sent_pkg::*;
(
  input  logic [3:0] crc_in,
  input  logic [3:0] nib,
  output logic [3:0] crc_out
);

  assign crc_out = TBL[{crc_in, 2'b00} +: 4] ^ nib;

endmodule

// File: rtl/sent_rx_crc_chk.sv
// SENT receive CRC4 checker: result pulse one cycle after the CRC nibble, no backpressure (strobes are
// never stalled). Optional saturating error counter enabled by SENT_CRC_ERR_CNT_EN.
module sent_rx_crc_chk
  import sent_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sent_crc_mode,
  input  logic       sent_frame_start,
  input  logic [2:0] sent_frame_len,
  input  logic       sent_frame_abort,
  input  logic       sent_nib_valid,
  input  logic [3:0] sent_nib_data,
  output logic       sent_crc_ack,
  output logic       sent_crc_ok,
  output logic [3:0] sent_crc_calc,
  output logic [3:0] sent_crc_rx,
  output logic       sent_len_err,
  output logic       sent_crc_busy
`ifdef SENT_CRC_ERR_CNT_EN
  , output logic [CNT_W-1:0] sent_crc_err_cnt
`endif
);

  sent_state_e state_q, state_d;
  logic [3:0]  crc_q, crc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic        mode_q, mode_d;
  logic        ack_q, ack_d;
  logic        ok_q, ok_d;
  logic [3:0]  calc_q, calc_d;
  logic [3:0]  rx_q, rx_d;
  logic        len_err_q, len_err_d;

  logic [3:0]  step_crc;
  logic [3:0]  aug_crc;
  logic [3:0]  exp_crc;
  logic        len_in_range;

  sent_crc4_nib u_step (
    .crc_in  (crc_q),
    .nib     (sent_nib_data),
    .crc_out (step_crc)
  );

  // Recommended mode appends one zero nibble; done combinationally so the compare costs no cycle.
  sent_crc4_nib u_aug (
    .crc_in  (crc_q),
    .nib     (4'h0),
    .crc_out (aug_crc)
  );

  assign exp_crc      = mode_q ? aug_crc : crc_q;
  assign len_in_range = (sent_frame_len >= LEN_MIN) && (sent_frame_len <= LEN_MAX);

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    mode_d    = mode_q;
    ack_d     = 1'b0;
    ok_d      = ok_q;
    calc_d    = calc_q;
    rx_d      = rx_q;
    len_err_d = 1'b0;

    // Priority: start, then abort, then nibble handling.
    if (sent_frame_start) begin
      if (len_in_range) begin
        len_d   = sent_frame_len;
        mode_d  = sent_crc_mode;
        crc_d   = CRC_SEED;
        cnt_d   = 3'd0;
        state_d = DATA;
      end else begin
        len_err_d = 1'b1;
        state_d   = IDLE;
      end
    end else if (sent_frame_abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        DATA: begin
          if (sent_nib_valid) begin
            crc_d = step_crc;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == (len_q - 3'd1)) begin
              state_d = CRC;
            end
          end
        end
        CRC: begin
          if (sent_nib_valid) begin
            rx_d    = sent_nib_data;
            calc_d  = exp_crc;
            ok_d    = (sent_nib_data == exp_crc);
            ack_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= CRC_SEED;
      cnt_q     <= 3'd0;
      len_q     <= 3'd0;
      mode_q    <= 1'b0;
      ack_q     <= 1'b0;
      ok_q      <= 1'b0;
      calc_q    <= 4'h0;
      rx_q      <= 4'h0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      ack_q     <= ack_d;
      ok_q      <= ok_d;
      calc_q    <= calc_d;
      rx_q      <= rx_d;
      len_err_q <= len_err_d;
    end
  end

  assign sent_crc_ack  = ack_q;
  assign sent_crc_ok   = ok_q;
  assign sent_crc_calc = calc_q;
  assign sent_crc_rx   = rx_q;
  assign sent_len_err  = len_err_q;
  assign sent_crc_busy = (state_q != IDLE);

`ifdef SENT_CRC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Counts failed results while the ack is visible; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (ack_q && !ok_q && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign sent_crc_err_cnt = err_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_sent_rx_crc_chk.sv
// Bench for sent_rx_crc_chk: table-driven frames plus hand sequences for abort/restart/reset corners.
// Expected results are queued when the CRC nibble is driven and popped on each ack.
module tb_sent_rx_crc_chk;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sent_crc_mode;
  logic       sent_frame_start;
  logic [2:0] sent_frame_len;
  logic       sent_frame_abort;
  logic       sent_nib_valid;
  logic [3:0] sent_nib_data;
  logic       sent_crc_ack;
  logic       sent_crc_ok;
  logic [3:0] sent_crc_calc;
  logic [3:0] sent_crc_rx;
  logic       sent_len_err;
  logic       sent_crc_busy;
`ifdef SENT_CRC_ERR_CNT_EN
  logic [1:0] sent_crc_err_cnt;
  int         exp_err;
  bit         err_pend;
`endif

  always #5 clk = ~clk;

  sent_rx_crc_chk #(.CNT_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sent_crc_mode    (sent_crc_mode),
    .sent_frame_start (sent_frame_start),
    .sent_frame_len   (sent_frame_len),
    .sent_frame_abort (sent_frame_abort),
    .sent_nib_valid   (sent_nib_valid),
    .sent_nib_data    (sent_nib_data),
    .sent_crc_ack     (sent_crc_ack),
    .sent_crc_ok      (sent_crc_ok),
    .sent_crc_calc    (sent_crc_calc),
    .sent_crc_rx      (sent_crc_rx),
    .sent_len_err     (sent_len_err),
    .sent_crc_busy    (sent_crc_busy)
`ifdef SENT_CRC_ERR_CNT_EN
    , .sent_crc_err_cnt (sent_crc_err_cnt)
`endif
  );

  typedef struct packed {
    logic       ok;
    logic [3:0] calc;
    logic [3:0] rx;
  } res_t;

  typedef struct {
    logic        mode;
    logic [2:0]  len;
    logic [23:0] data;
    logic [3:0]  rx;
    int          gap;
    logic        exp_ok;
    logic [3:0]  exp_calc;
  } vec_t;

  res_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    res_t e;
`ifdef SENT_CRC_ERR_CNT_EN
    if (err_pend) begin
      check("err_cnt", 32'(sent_crc_err_cnt), 32'(exp_err));
      err_pend = 1'b0;
    end
`endif
    if (rst_n && sent_crc_ack) begin
      if (sbq.size() == 0) begin
        check("unexpected_ack", 32'(sent_crc_ack), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("ack_ok", 32'(sent_crc_ok), 32'(e.ok));
        check("ack_calc", 32'(sent_crc_calc), 32'(e.calc));
        check("ack_rx", 32'(sent_crc_rx), 32'(e.rx));
`ifdef SENT_CRC_ERR_CNT_EN
        if (!e.ok) begin
          if (exp_err < 3) exp_err++;
          err_pend = 1'b1;
        end
`endif
      end
    end
  end

  task automatic start_frame(input logic mode, input logic [2:0] len);
    sent_crc_mode    = mode;
    sent_frame_len   = len;
    sent_frame_start = 1'b1;
    tick();
    sent_frame_start = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] d);
    sent_nib_valid = 1'b1;
    sent_nib_data  = d;
    tick();
    sent_nib_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0) break;
      tick();
    end
    check("ack_drain", 32'(sbq.size()), 32'd0);
  endtask

  task automatic send_data(input logic [2:0] len, input logic [23:0] data, input int gap);
    for (int i = 0; i < int'(len); i++) begin
      repeat (gap) tick();
      send_nib(data[4*i +: 4]);
    end
  endtask

  task automatic finish_frame(input logic [3:0] rx, input logic eok, input logic [3:0] ecalc);
    sbq.push_back({eok, ecalc, rx});
    send_nib(rx);
    drain();
  endtask

  task automatic run_frame(input vec_t v);
    start_frame(v.mode, v.len);
    send_data(v.len, v.data, v.gap);
    repeat (v.gap) tick();
    finish_frame(v.rx, v.exp_ok, v.exp_calc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    vec_t bad;
    vecs[0] = '{1'b1, 3'd6, 24'h000000, 4'h5, 0, 1'b1, 4'h5};
    vecs[1] = '{1'b0, 3'd6, 24'h000000, 4'hF, 0, 1'b1, 4'hF};
    vecs[2] = '{1'b1, 3'd6, 24'h654321, 4'h3, 0, 1'b0, 4'h2};
    vecs[3] = '{1'b0, 3'd6, 24'h654321, 4'hD, 0, 1'b1, 4'hD};
    vecs[4] = '{1'b1, 3'd3, 24'h000CBA, 4'h1, 0, 1'b1, 4'h1};
    vecs[5] = '{1'b1, 3'd3, 24'h000CBA, 4'h1, 11, 1'b1, 4'h1};
    vecs[6] = '{1'b0, 3'd3, 24'h000CBA, 4'h8, 0, 1'b1, 4'h8};
    vecs[7] = '{1'b0, 3'd1, 24'h000007, 4'h4, 0, 1'b1, 4'h4};
    bad     = vecs[2];

    rst_n = 1'b0;
    sent_crc_mode = 1'b0; sent_frame_start = 1'b0; sent_frame_len = 3'd0;
    sent_frame_abort = 1'b0; sent_nib_valid = 1'b0; sent_nib_data = 4'h0;
`ifdef SENT_CRC_ERR_CNT_EN
    exp_err = 0; err_pend = 1'b0;
`endif
    #23;
    check("reset_outputs", {sent_crc_ack, sent_crc_ok, sent_crc_calc, sent_crc_rx, sent_len_err, sent_crc_busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_frame(vecs[i]);

    // Length errors, and nibbles while idle must not produce an ack.
    start_frame(1'b1, 3'd0);
    check("len0_err", 32'(sent_len_err), 32'd1);
    check("len0_busy", 32'(sent_crc_busy), 32'd0);
    tick();
    check("len_err_pulse", 32'(sent_len_err), 32'd0);
    start_frame(1'b0, 3'd7);
    check("len7_err", 32'(sent_len_err), 32'd1);
    check("len7_busy", 32'(sent_crc_busy), 32'd0);
    send_nib(4'h5); send_nib(4'h5); send_nib(4'h5);
    repeat (3) tick();

    // Abort after 3 of 6 nibbles; previous result must be retained.
    start_frame(1'b1, 3'd6);
    check("busy_data", 32'(sent_crc_busy), 32'd1);
    send_data(3'd3, 24'h000321, 0);
    sent_frame_abort = 1'b1; tick(); sent_frame_abort = 1'b0;
    check("abort_busy", 32'(sent_crc_busy), 32'd0);
    check("abort_hold", {sent_crc_ok, sent_crc_calc, sent_crc_rx}, {23'd0, 1'b1, 4'h4, 4'h4});
    run_frame(vecs[0]);

    // Abort together with the CRC nibble: no ack, result held.
    start_frame(1'b1, 3'd6);
    send_data(3'd6, 24'h000000, 0);
    check("busy_crc", 32'(sent_crc_busy), 32'd1);
    sent_nib_valid = 1'b1; sent_nib_data = 4'h7; sent_frame_abort = 1'b1;
    tick();
    sent_nib_valid = 1'b0; sent_frame_abort = 1'b0;
    repeat (3) tick();
    check("abort_crc_busy", 32'(sent_crc_busy), 32'd0);
    check("abort_crc_hold", {sent_crc_ok, sent_crc_calc, sent_crc_rx}, {23'd0, 1'b1, 4'h5, 4'h5});

    // Start mid-frame restarts cleanly.
    start_frame(1'b1, 3'd6);
    send_data(3'd2, 24'h000099, 0);
    run_frame(vecs[3]);

    // Start together with abort: start wins.
    sent_crc_mode = 1'b1; sent_frame_len = 3'd3; sent_frame_start = 1'b1; sent_frame_abort = 1'b1;
    tick();
    sent_frame_start = 1'b0; sent_frame_abort = 1'b0;
    check("start_abort_busy", 32'(sent_crc_busy), 32'd1);
    send_data(3'd3, 24'h000CBA, 0);
    finish_frame(4'h1, 1'b1, 4'h1);

    // Start together with a nibble: the nibble is dropped.
    sent_crc_mode = 1'b1; sent_frame_len = 3'd3; sent_frame_start = 1'b1;
    sent_nib_valid = 1'b1; sent_nib_data = 4'hF;
    tick();
    sent_frame_start = 1'b0; sent_nib_valid = 1'b0;
    send_data(3'd3, 24'h000CBA, 0);
    finish_frame(4'h1, 1'b1, 4'h1);

    // Reset mid-frame.
    start_frame(1'b0, 3'd6);
    send_data(3'd2, 24'h000021, 0);
    rst_n = 1'b0;
    #2;
    check("midreset_outputs", {sent_crc_ack, sent_crc_ok, sent_crc_calc, sent_crc_rx, sent_len_err, sent_crc_busy}, 32'd0);
`ifdef SENT_CRC_ERR_CNT_EN
    check("midreset_err_cnt", 32'(sent_crc_err_cnt), 32'd0);
    exp_err = 0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_data(3'd4, 24'h006543, 0);
    repeat (3) tick();
    check("post_reset_busy", 32'(sent_crc_busy), 32'd0);

    // Four bad frames: error counter saturates at 3 with a 2-bit counter.
    for (int k = 0; k < 4; k++) run_frame(bad);

    repeat (5) tick();
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sent_rx_crc_chk.md
Name: sent_rx_crc_chk

Overview:
Receive-side SENT CRC checker; the counterpart of the transmit CRC generator.
- Sits after the SENT pulse/nibble decoder.
- Consumes the decoded data nibbles of one fast-channel frame, then the received CRC nibble.
- Computes the SAE J2716 CRC4 in legacy or recommended mode and compares it with the received nibble.
- Emits a single-cycle result pulse with pass/fail, both CRC values and an optional error counter.

Parameters:
CNT_W, 16, width of the saturating CRC error counter (used only with SENT_CRC_ERR_CNT_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- sent_crc_mode  in  1  1 = recommended (zero-nibble augmented), 0 = legacy; sampled on sent_frame_start
- sent_frame_start  in  1  pulse: new frame begins; latches mode and length, seeds CRC
- sent_frame_len  in  3  number of data nibbles (1..6), sampled on sent_frame_start
- sent_frame_abort  in  1  pulse: decoder detected a framing or pulse error; discard the frame
- sent_nib_valid  in  1  one-cycle strobe: sent_nib_data is valid
- sent_nib_data  in  4  data nibble (status nibble excluded), then the CRC nibble
- sent_crc_ack  out  1  one-cycle pulse: check complete
- sent_crc_ok  out  1  1 = received CRC equals computed CRC; valid while sent_crc_ack is high, held until the next ack
- sent_crc_calc  out  4  computed CRC, held until the next ack
- sent_crc_rx  out  4  received CRC nibble, held until the next ack
- sent_len_err  out  1  one-cycle pulse: sent_frame_len out of range at start
- sent_crc_busy  out  1  1 while a frame is in progress (DATA or CRC state)

Behaviour:
Reset
- All outputs are 0; state is IDLE; internal CRC register is 4'h5; nibble counter is 0.

CRC arithmetic
- Nibble step: crc_next = TBL[crc] ^ nib.
- TBL = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5} (x^4+x^3+x^2+1). Seed is 4'h5.
- Expected CRC in legacy mode: crc after the last data nibble.
- Expected CRC in recommended mode: TBL[crc] (one extra zero-nibble step). It is computed combinationally at compare time, so there is no extra cycle.

State machine: IDLE, DATA, CRC
- sent_frame_start with len in 1..6, from any state: latch len and mode, crc <= 5, cnt <= 0, go to DATA. Any frame in progress is dropped with no ack.
- sent_frame_start with len 0 or 7: sent_len_err pulses next cycle; go to IDLE.
- DATA: each sent_nib_valid updates crc and increments cnt. When cnt reaches len-1 and valid is high, go to CRC.
- CRC: on sent_nib_valid, capture the nibble into sent_crc_rx and write the expected value into sent_crc_calc. sent_crc_ok <= (equal). sent_crc_ack pulses the next cycle (1-cycle latency from the CRC nibble). Return to IDLE.
- IDLE: sent_nib_valid is ignored.

Simultaneous events
- sent_frame_abort in DATA or CRC: go to IDLE, no ack; result outputs keep their previous values.
- start together with abort: start wins.
- start together with nib_valid: start wins and the nibble is dropped.
- abort together with the CRC nibble: abort wins and there is no ack.

Reset mid-frame
- Asynchronous return to reset values; no ack.

Optional Feature:
SENT_CRC_ERR_CNT_EN
- Defined: adds output sent_crc_err_cnt [CNT_W-1:0], reset 0.
  - Increments in the cycle sent_crc_ack is high with sent_crc_ok == 0.
  - Saturates at all-ones.
  - Abort and length errors do not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package sent_pkg holds:
  - CRC4 table constant TBL;
  - seed constant 4'h5;
  - length limits (min 1, max 6);
  - state enum (IDLE, DATA, CRC).
- One sub-module: sent_crc4_nib, combinational, (crc_in[3:0], nib[3:0]) -> crc_out = TBL[crc_in]^nib.
  - It is instanced twice: once for the data step, once with nib = 0 for the recommended-mode augmentation.

Test Plan:
1. Recommended mode, len=6, data 0,0,0,0,0,0, CRC nibble 5 -> ack one cycle after the CRC nibble, ok=1, calc=4'h5. Legacy mode, same data, CRC nibble F -> ok=1, calc=4'hF.
2. Recommended mode, len=6, data 1,2,3,4,5,6, CRC nibble 3 -> ok=0, calc=4'h2, rx=4'h3; with SENT_CRC_ERR_CNT_EN, err_cnt goes 0->1. Legacy mode, same data, CRC nibble D -> ok=1, calc=4'hD.
3. Recommended mode, len=3, data A,B,C, CRC nibble 1 -> ok=1, calc=4'h1; nibble valid strobes spaced 12 cycles apart give the same result.
4. Start with len=0, then with len=7 -> sent_len_err pulses each time; busy stays 0; no ack.
5. Abort after 3 of 6 nibbles, then a new start with scenario 1 data -> exactly one ack, ok=1. A start issued mid-frame restarts cleanly. rst_n asserted mid-frame -> all outputs 0 and no ack.
6. With SENT_CRC_ERR_CNT_EN and CNT_W=2: four bad frames -> err_cnt goes 1,2,3,3 (saturates).
